// File: rtl/ghost_pkg.sv
// Shared constants, types and state encodings for the ghost step controller.
package ghost_pkg;

    localparam int unsigned GRID_W   = 32;
    localparam int unsigned MAP_COLS = 22;
    localparam int unsigned MAP_ROWS = 32;

    typedef logic [9:0]          pos_t;
    typedef logic [4:0]          row_addr_t;
    typedef logic [MAP_COLS-1:0] map_row_t;

    typedef enum logic [1:0] {
        UP    = 2'd0,
        RIGHT = 2'd1,
        DOWN  = 2'd2,
        LEFT  = 2'd3
    } ghost_dir_e;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        FETCH  = 3'd1,
        DRAIN  = 3'd2,
        EVAL   = 3'd3,
        COMMIT = 3'd4
    } step_state_e;

endpackage

// File: rtl/ghost_pos_check.sv
// Judges a proposed next position against the current one and produces the position to commit.
// Row-edge moves wrap when GHOST_STEP_TUNNEL_EN is defined, otherwise they are rejected.
module ghost_pos_check #(
    parameter int unsigned MAP_COLS = ghost_pkg::MAP_COLS,
    parameter int unsigned GRID_W   = ghost_pkg::GRID_W
) (
    input  logic [9:0] ghost_pos,
    input  logic [9:0] next_pos,
    output logic       valid,
    output logic [9:0] commit_pos
);
    import ghost_pkg::*;

    localparam pos_t STRIDE   = pos_t'(GRID_W);
    localparam pos_t LAST_COL = pos_t'(MAP_COLS - 1);

    pos_t col_s;
    pos_t row_base_s;

    // Split the current position into row base and column
    always_comb begin
        col_s      = ghost_pos % STRIDE;
        row_base_s = ghost_pos - col_s;
    end

    // Classify the move; all arithmetic wraps in 10 bits
    always_comb begin
        valid      = 1'b0;
        commit_pos = ghost_pos;
        if ((next_pos == ghost_pos) || (next_pos == ghost_pos + STRIDE) ||
            (next_pos == ghost_pos - STRIDE)) begin
            valid      = 1'b1;
            commit_pos = next_pos;
        end else if (next_pos == ghost_pos + 10'd1) begin
            if (col_s < LAST_COL) begin
                valid      = 1'b1;
                commit_pos = next_pos;
            end else begin
`ifdef GHOST_STEP_TUNNEL_EN
                valid      = (col_s == LAST_COL);
                commit_pos = (col_s == LAST_COL) ? row_base_s : ghost_pos;
`else
                valid      = 1'b0;
                commit_pos = ghost_pos;
`endif
            end
        end else if (next_pos == ghost_pos - 10'd1) begin
            if ((col_s != 10'd0) && (col_s <= LAST_COL)) begin
                valid      = 1'b1;
                commit_pos = next_pos;
            end else begin
`ifdef GHOST_STEP_TUNNEL_EN
                valid      = (col_s == 10'd0);
                commit_pos = (col_s == 10'd0) ? (row_base_s + LAST_COL) : ghost_pos;
`else
                valid      = 1'b0;
                commit_pos = ghost_pos;
`endif
            end
        end else begin
            valid      = 1'b0;
            commit_pos = ghost_pos;
        end
    end

endmodule

// File: rtl/ghost_step_ctrl.sv
// Ghost step sequencer: fetches four neighbour map rows, waits for the next-location result, commits it.
// Optional row-edge wrap via GHOST_STEP_TUNNEL_EN (handled in ghost_pos_check).
module ghost_step_ctrl #(
    parameter logic [9:0]  START_POS = 10'd330,
    parameter int unsigned MAP_COLS  = ghost_pkg::MAP_COLS,
    parameter int unsigned MAP_ROWS  = ghost_pkg::MAP_ROWS,
    parameter int unsigned GRID_W    = ghost_pkg::GRID_W
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     move_tick,
    input  logic [3:0][4:0]          nb_addr,
    input  logic [9:0]               next_pos,
    input  logic [MAP_COLS-1:0]      map_rd_data,
    output logic                     map_rd_en,
    output logic [4:0]               map_rd_addr,
    output logic [3:0][MAP_COLS-1:0] nb_rows,
    output logic [9:0]               ghost_pos,
    output logic                     busy,
    output logic                     step_done,
    output logic                     step_err
);
    import ghost_pkg::*;

    step_state_e              state_q, state_d;
    ghost_dir_e               idx_q, idx_d;
    logic [3:0][MAP_COLS-1:0] nb_rows_q;
    pos_t                     ghost_pos_q;
    logic                     cap_vld_q;
    logic                     cap_wall_q;
    ghost_dir_e               cap_idx_q;
    logic                     commit_ok_q;
    logic                     slot_ok_s;
    logic                     chk_valid_s;
    pos_t                     chk_pos_s;

    assign slot_ok_s = ({27'd0, nb_addr[idx_q]} < 32'(MAP_ROWS));
    assign nb_rows   = nb_rows_q;
    assign ghost_pos = ghost_pos_q;

    ghost_pos_check #(
        .MAP_COLS (MAP_COLS),
        .GRID_W   (GRID_W)
    ) u_check (
        .ghost_pos  (ghost_pos_q),
        .next_pos   (next_pos),
        .valid      (chk_valid_s),
        .commit_pos (chk_pos_s)
    );

    // State register and slot index
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            idx_q   <= UP;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
        end
    end

    // Next-state logic; ticks outside IDLE are dropped
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        case (state_q)
            IDLE: begin
                if (move_tick) begin
                    state_d = FETCH;
                    idx_d   = UP;
                end else begin
                    state_d = IDLE;
                end
            end
            FETCH: begin
                if (idx_q == LEFT) begin
                    state_d = DRAIN;
                end else begin
                    idx_d = ghost_dir_e'(idx_q + 2'd1);
                end
            end
            DRAIN:   state_d = EVAL;
            EVAL:    state_d = COMMIT;
            COMMIT:  state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Output decode from the current state
    always_comb begin
        map_rd_en   = 1'b0;
        map_rd_addr = 5'd0;
        busy        = 1'b0;
        step_done   = 1'b0;
        step_err    = 1'b0;
        case (state_q)
            FETCH: begin
                busy = 1'b1;
                if (slot_ok_s) begin
                    map_rd_en   = 1'b1;
                    map_rd_addr = nb_addr[idx_q];
                end else begin
                    map_rd_en   = 1'b0;
                end
            end
            DRAIN, EVAL: busy = 1'b1;
            COMMIT: begin
                step_done = commit_ok_q;
                step_err  = ~commit_ok_q;
            end
            default: busy = 1'b0;
        endcase
    end

    // Row capture one cycle behind each issue, and position commit at the end of EVAL
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            nb_rows_q   <= {(4*MAP_COLS){1'b1}};
            ghost_pos_q <= START_POS;
            cap_vld_q   <= 1'b0;
            cap_wall_q  <= 1'b0;
            cap_idx_q   <= UP;
            commit_ok_q <= 1'b0;
        end else begin
            cap_vld_q  <= (state_q == FETCH);
            cap_wall_q <= ~slot_ok_s;
            cap_idx_q  <= idx_q;
            if (cap_vld_q) begin
                nb_rows_q[cap_idx_q] <= cap_wall_q ? {MAP_COLS{1'b1}} : map_rd_data;
            end
            if (state_q == EVAL) begin
                commit_ok_q <= chk_valid_s;
                ghost_pos_q <= chk_pos_s;
            end
        end
    end

endmodule

// File: tb/tb_ghost_step_ctrl.sv
// Scoreboard bench for ghost_step_ctrl: random and directed steps against a rule-level reference model.
module tb_ghost_step_ctrl;
    import ghost_pkg::*;

    localparam int ROWS = 31;
`ifdef GHOST_STEP_TUNNEL_EN
    localparam bit TUNNEL = 1'b1;
`else
    localparam bit TUNNEL = 1'b0;
`endif

    typedef struct {
        int                ecy;
        bit                ok;
        logic [9:0]        pos;
        logic [3:0][21:0]  rows;
    } sb_item_t;

    typedef struct {
        int         ecy;
        logic [4:0] addr;
    } rd_item_t;

    logic             clk = 1'b0;
    logic             reset = 1'b0;
    logic             move_tick = 1'b0;
    logic [3:0][4:0]  nb_addr;
    logic [9:0]       next_pos = 10'd330;
    logic [21:0]      map_rd_data = 22'd0;
    logic             map_rd_en;
    logic [4:0]       map_rd_addr;
    logic [3:0][21:0] nb_rows;
    logic [9:0]       ghost_pos;
    logic             busy;
    logic             step_done;
    logic             step_err;

    map_row_t ram [32];
    sb_item_t sb_q[$];
    rd_item_t rd_q[$];
    int edge_cnt  = 0;
    int free_at   = 0;
    int busy_from = 1;
    int busy_to   = 0;
    int model_pos = 330;
    int n_cmp = 0;
    int n_err = 0;

    ghost_step_ctrl #(.MAP_ROWS(ROWS)) dut (
        .clk         (clk),
        .reset       (reset),
        .move_tick   (move_tick),
        .nb_addr     (nb_addr),
        .next_pos    (next_pos),
        .map_rd_data (map_rd_data),
        .map_rd_en   (map_rd_en),
        .map_rd_addr (map_rd_addr),
        .nb_rows     (nb_rows),
        .ghost_pos   (ghost_pos),
        .busy        (busy),
        .step_done   (step_done),
        .step_err    (step_err)
    );

    initial forever #5 clk = ~clk;

    always @(posedge clk) edge_cnt <= edge_cnt + 1;

    // Map RAM with one-cycle read latency
    always @(posedge clk) if (map_rd_en) map_rd_data <= ram[map_rd_addr];

    // Next-location stage addressing: rows above, same, below, same
    always_comb begin
        nb_addr[0] = ghost_pos[9:5] - 5'd1;
        nb_addr[1] = ghost_pos[9:5];
        nb_addr[2] = ghost_pos[9:5] + 5'd1;
        nb_addr[3] = ghost_pos[9:5];
    end

    task automatic chk(input string name, input logic [127:0] got, input logic [127:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h want %0h (edge %0d)", name, got, exp, edge_cnt);
        end
    endtask

    function automatic void ref_step(input int pos, input int np, output bit ok, output int npos);
        int row = pos / 32;
        int col = pos % 32;
        ok   = 1'b0;
        npos = pos;
        if (np == pos || np == (pos + 32) % 1024 || np == (pos + 992) % 1024) begin
            ok = 1'b1; npos = np;
        end else if (np == (pos + 1) % 1024) begin
            if (col + 1 < 22) begin ok = 1'b1; npos = np; end
            else if (TUNNEL && col == 21) begin ok = 1'b1; npos = row * 32; end
        end else if (np == (pos + 1023) % 1024) begin
            if (col >= 1 && col - 1 < 22) begin ok = 1'b1; npos = np; end
            else if (TUNNEL && col == 0) begin ok = 1'b1; npos = row * 32 + 21; end
        end
    endfunction

    task automatic accept(input int n);
        sb_item_t it;
        rd_item_t r;
        int row = model_pos / 32;
        int addr [4];
        int npos;
        bit ok;
        addr[0] = (row + 31) % 32;
        addr[1] = row;
        addr[2] = (row + 1) % 32;
        addr[3] = row;
        for (int s = 0; s < 4; s++) begin
            if (addr[s] < ROWS) begin
                it.rows[s] = ram[addr[s]];
                r.ecy  = n + s;
                r.addr = 5'(addr[s]);
                rd_q.push_back(r);
            end else begin
                it.rows[s] = {22{1'b1}};
            end
        end
        ref_step(model_pos, int'(next_pos), ok, npos);
        it.ecy = n;
        it.ok  = ok;
        it.pos = 10'(npos);
        sb_q.push_back(it);
        model_pos = npos;
        free_at   = n + 8;
        busy_from = n;
        busy_to   = n + 5;
    endtask

    task automatic issue_tick(input bit set_np, input logic [9:0] np);
        if (set_np) next_pos = np;
        move_tick = 1'b1;
        if (edge_cnt + 1 >= free_at) accept(edge_cnt + 1);
        @(posedge clk); #1;
        move_tick = 1'b0;
    endtask

    task automatic wait_idle();
        int guard = 0;
        while (edge_cnt + 1 < free_at && guard < 50) begin
            @(posedge clk); #1;
            guard++;
        end
    endtask

    task automatic do_step(input int np);
        wait_idle();
        issue_tick(1'b1, 10'(np));
        wait_idle();
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_pos"}, ghost_pos, 10'd330);
        chk({tag, "_rows"}, nb_rows, {88{1'b1}});
        chk({tag, "_busy"}, busy, 1'b0);
        chk({tag, "_rd_en"}, map_rd_en, 1'b0);
        chk({tag, "_rd_addr"}, map_rd_addr, 5'd0);
        chk({tag, "_done"}, step_done, 1'b0);
        chk({tag, "_err"}, step_err, 1'b0);
    endtask

    // Monitor: busy window, read-port issues and commit pulses against the scoreboard
    always @(negedge clk) begin
        if (!reset) begin
            chk("busy", busy, (edge_cnt >= busy_from && edge_cnt <= busy_to));
            if (map_rd_en) begin
                if (rd_q.size() == 0) begin
                    chk("rd_stray", map_rd_en, 1'b0);
                end else begin
                    rd_item_t r;
                    r = rd_q.pop_front();
                    chk("rd_addr", map_rd_addr, r.addr);
                    chk("rd_cycle", edge_cnt, r.ecy);
                end
            end
            if (step_done || step_err) begin
                if (sb_q.size() == 0) begin
                    chk("stray_pulse", {step_done, step_err}, 2'b00);
                end else begin
                    sb_item_t it;
                    it = sb_q.pop_front();
                    chk("pulse_kind", {step_done, step_err}, {it.ok, ~it.ok});
                    chk("commit_pos", ghost_pos, it.pos);
                    chk("commit_cycle", edge_cnt, it.ecy + 6);
                    chk("nb_rows", nb_rows, it.rows);
                end
            end
        end
    end

    initial begin
        for (int i = 0; i < 32; i++) ram[i] = 22'($urandom);
        ram[9] = 22'd0;
        #1 reset = 1'b1;
        #2 check_reset_outputs("reset");
        @(posedge clk); @(posedge clk); #1;
        reset = 1'b0;

        // First step plus an ignored tick three cycles in
        wait_idle();
        issue_tick(1'b1, 10'd298);
        @(posedge clk); #1;
        @(posedge clk); #1;
        issue_tick(1'b0, 10'd0);
        wait_idle();

        for (int i = 0; i < 9; i++) do_step((model_pos + 992) % 1024);
        do_step((model_pos + 992) % 1024);
        for (int i = 0; i < 10; i++) do_step((model_pos + 32) % 1024);
        for (int i = 0; i < 11; i++) do_step(model_pos + 1);
        do_step(model_pos + 1);
        do_step(400);
        for (int i = 0; i < 22 && (model_pos % 32) != 0; i++) do_step(model_pos - 1);
        do_step((model_pos + 1023) % 1024);

        // Reset in the middle of a step
        wait_idle();
        issue_tick(1'b1, 10'((model_pos + 32) % 1024));
        @(posedge clk); #1;
        @(posedge clk); #1;
        reset = 1'b1;
        #1 check_reset_outputs("midreset");
        sb_q.delete();
        rd_q.delete();
        model_pos = 330;
        free_at   = 0;
        busy_from = 1;
        busy_to   = 0;
        @(posedge clk); #1;
        reset = 1'b0;
        do_step(331);

        for (int k = 0; k < 200; k++) begin
            int gap = $urandom_range(0, 10);
            repeat (gap) begin @(posedge clk); #1; end
            if (edge_cnt + 1 >= free_at) begin
                int np;
                case ($urandom_range(0, 7))
                    0:       np = model_pos;
                    1, 6:    np = (model_pos + 1) % 1024;
                    2, 7:    np = (model_pos + 1023) % 1024;
                    3:       np = (model_pos + 32) % 1024;
                    4:       np = (model_pos + 992) % 1024;
                    default: np = int'($urandom_range(0, 1023));
                endcase
                issue_tick(1'b1, 10'(np));
            end else begin
                issue_tick(1'b0, 10'd0);
            end
        end

        wait_idle();
        repeat (10) begin @(posedge clk); #1; end
        chk("sb_drained", 32'(sb_q.size()), 32'd0);
        chk("rd_drained", 32'(rd_q.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
